mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 8-input, 1-output select mux among 8 requesters.
- Requester i owning the grant means the mux selects its input i.
- Drives the mux select lines (s0 = sel[0], s1 = sel[1], s2 = sel[2]) and a one-hot grant vector.
- Caps ownership time with a burst limit so every requester is served fairly.

---
 rtl/mux8_arb_pkg.sv | 25 ++
 rtl/mux8_rr_arbiter_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/mux8_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux8_rr_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux8_arb_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
//   NUM_REQ / SEL_W : requester count and mux select width
//   state_e         : arbiter FSM state encoding
//   onehot_to_idx   : converts a one-hot grant vector to its bit index
package mux8_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Valid for one-hot or all-zero inputs (zero maps to index 0).
    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the requesters and the mux arbiter.
//   req   : request vector, bit i = requester i wants the mux
//   done  : current owner has finished
//   grant : one-hot grant (zero when idle)
//   sel   : mux select, index of current or last owner
//   busy  : a grant is active
// slave modport is the arbiter side, master modport the requester side.
interface mux8_rr_arbiter_if;
    import mux8_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output busy
    );

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  busy
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner selection.
//   req   : request vector
//   ptr   : highest-priority index for this arbitration
//   found : at least one request is present
//   idx   : first set request bit at or above ptr, wrapping 7 -> 0
module rr_priority_pick
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        // Slicing the doubled vector is a right-rotate by ptr: req_rot[k] = req[(ptr+k) mod 8].
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: NUM_REQ];
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) off = SEL_W'(i);
        end
        found = |req;
        // Natural 3-bit wrap gives the mod-8 add back.
        idx   = off + ptr;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters, with an
// optional burst limit on each ownership.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux8_rr_arbiter_if (req/done in, grant/sel/busy out)
// Parameters:
//   MAX_BURST : max consecutive grant cycles per ownership, 0 = unlimited
//   CNT_W     : burst counter width, 2**CNT_W >= MAX_BURST
//
// state | meaning
// IDLE  | no owner; arbitrate on any request, grant lands next edge
// GRANT | one owner holds the mux until done, req drop or burst expiry
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mux8_rr_arbiter_if.slave bus
);

    localparam bit               BURST_ON   = (MAX_BURST != 0);
    localparam logic [CNT_W-1:0] BURST_LAST = BURST_ON ? CNT_W'(MAX_BURST - 1) : '1;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SEL_W-1:0]   owner;
    logic               burst_last;
    logic               release_own;

    rr_priority_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        owner       = onehot_to_idx(grant_q);
        burst_last  = BURST_ON && (cnt_q == BURST_LAST);
        // Any combination of release causes collapses into one release.
        release_own = bus.done || !bus.req[owner] || burst_last;

        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_own) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = owner + 1'b1;
                    // sel deliberately holds the last owner so the mux output stays put.
                end else if (cnt_q != BURST_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_drv;
    logic       done_drv;
    logic [7:0] mux_in;
    logic       res4;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: k = 0 is the MAX_BURST = 4 instance, k = 1 the MAX_BURST = 1 instance.
    int m_owner [2];
    int m_ptr   [2];
    int m_cnt   [2];
    int m_sel   [2];
    int m_burst [2] = '{4, 1};

    mux8_rr_arbiter_if if4 ();
    mux8_rr_arbiter_if if1 ();

    assign if4.req  = req_drv;
    assign if4.done = done_drv;
    assign if1.req  = req_drv;
    assign if1.done = done_drv;

    // Behavioural 8:1 mux with inputs a..h on bits 0..7.
    assign res4 = mux_in[if4.sel];

    mux8_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    mux8_rr_arbiter #(.MAX_BURST(1), .CNT_W(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_cnt[k]   = 0;
            m_sel[k]   = 0;
        end
    endtask

    // Next-edge behaviour computed from the arbitration rules using the current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_owner[k] < 0) begin
                for (int i = 0; i < 8; i++) begin
                    int c;
                    c = (m_ptr[k] + i) % 8;
                    if (req_drv[c] && m_owner[k] < 0) begin
                        m_owner[k] = c;
                        m_sel[k]   = c;
                        m_cnt[k]   = 0;
                    end
                end
            end else begin
                bit rel;
                rel = done_drv || !req_drv[m_owner[k]]
                      || (m_burst[k] != 0 && m_cnt[k] == m_burst[k] - 1);
                if (rel) begin
                    m_ptr[k]   = (m_owner[k] + 1) % 8;
                    m_owner[k] = -1;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg4, eg1;
        eg4 = (m_owner[0] < 0) ? 8'h00 : 8'(1 << m_owner[0]);
        eg1 = (m_owner[1] < 0) ? 8'h00 : 8'(1 << m_owner[1]);
        chk({tag, ".grant4"}, 32'(if4.grant), 32'(eg4));
        chk({tag, ".sel4"},   32'(if4.sel),   32'(m_sel[0]));
        chk({tag, ".busy4"},  32'(if4.busy),  32'(m_owner[0] >= 0));
        chk({tag, ".grant1"}, 32'(if1.grant), 32'(eg1));
        chk({tag, ".sel1"},   32'(if1.sel),   32'(m_sel[1]));
        chk({tag, ".busy1"},  32'(if1.busy),  32'(m_owner[1] >= 0));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases mid-cycle.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_grant4"}, 32'(if4.grant), 32'h00);
        chk({tag, ".rst_sel4"},   32'(if4.sel),   32'h0);
        chk({tag, ".rst_busy4"},  32'(if4.busy),  32'h0);
        chk({tag, ".rst_grant1"}, 32'(if1.grant), 32'h00);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_burst [11];

        rst_n    = 1'b0;
        req_drv  = 8'hFF;
        done_drv = 1'b0;
        mux_in   = 8'h80;
        model_reset();

        // Reset with all requests high, before any clock edge.
        #3;
        chk("reset.grant", 32'(if4.grant), 32'h00);
        chk("reset.sel",   32'(if4.sel),   32'h0);
        chk("reset.busy",  32'(if4.busy),  32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle("reset_release");
        chk("reset_release.grant01", 32'(if4.grant), 32'h01);

        // Single requester.
        apply_reset("single");
        req_drv = 8'h00;
        cycle("single.idle");
        req_drv = 8'h08;
        cycle("single.grant");
        chk("single.grant08", 32'(if4.grant), 32'h08);
        chk("single.sel3",    32'(if4.sel),   32'h3);
        chk("single.busy",    32'(if4.busy),  32'h1);
        req_drv = 8'h00;
        cycle("single.drop");
        chk("single.drop_grant", 32'(if4.grant), 32'h00);
        chk("single.drop_sel3",  32'(if4.sel),   32'h3);

        // Round-robin wrap on the MAX_BURST = 1 instance.
        apply_reset("rr");
        req_drv = 8'hFF;
        for (int k = 0; k <= 16; k++) begin
            logic [7:0] eg;
            eg = (k % 2 == 0) ? 8'(1 << ((k / 2) % 8)) : 8'h00;
            cycle("rr");
            chk($sformatf("rr.seq%0d", k), 32'(if1.grant), 32'(eg));
        end

        // Burst limit on the MAX_BURST = 4 instance.
        apply_reset("burst");
        req_drv = 8'h81;
        exp_burst = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                      8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
        for (int k = 0; k < 11; k++) begin
            cycle("burst");
            chk($sformatf("burst.seq%0d", k), 32'(if4.grant), 32'(exp_burst[k]));
        end

        // done releases owner 2, waiting requester 5 follows; done in IDLE is ignored.
        apply_reset("done");
        req_drv = 8'h24;
        cycle("done.g1");
        chk("done.g1_grant04", 32'(if4.grant), 32'h04);
        cycle("done.g2");
        chk("done.g2_grant04", 32'(if4.grant), 32'h04);
        done_drv = 1'b1;
        cycle("done.rel");
        chk("done.rel_grant00", 32'(if4.grant), 32'h00);
        done_drv = 1'b0;
        cycle("done.next");
        chk("done.next_grant20", 32'(if4.grant), 32'h20);
        req_drv = 8'h00;
        cycle("done.drop");
        done_drv = 1'b1;
        cycle("done.idle_pulse");
        chk("done.idle_grant00", 32'(if4.grant), 32'h00);
        done_drv = 1'b0;
        req_drv  = 8'h02;
        cycle("done.after_idle");
        chk("done.after_idle_grant02", 32'(if4.grant), 32'h02);

        // Mux integration and asynchronous reset while granted.
        apply_reset("mux");
        req_drv = 8'h80;
        cycle("mux.grant");
        chk("mux.sel7", 32'(if4.sel), 32'h7);
        chk("mux.res1", 32'(res4),    32'h1);
        cycle("mux.hold");
        rst_n = 1'b0;
        #1;
        chk("mux.rst_grant", 32'(if4.grant), 32'h00);
        chk("mux.rst_sel0",  32'(if4.sel),   32'h0);
        chk("mux.rst_res0",  32'(res4),      32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        req_drv = 8'hFF;
        cycle("mux.resume");
        chk("mux.resume_grant01", 32'(if4.grant), 32'h01);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       req_drv = 8'($urandom);
                1:       req_drv = 8'($urandom) & 8'($urandom);
                2:       req_drv = 8'h01 << $urandom_range(0, 7);
                default: req_drv = req_drv;
            endcase
            done_drv = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
